wave_gen: RTL
=============

WAVE_GEN -- requirements
Module: wave_gen

Interface
REQ-001 Parameter WIDTH, default 8: waveform sample and PWM resolution, in bits.
REQ-002 Parameter PRESCALE_W, default 16: prescaler divisor width, in bits.
REQ-003 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 enable  input  1  high = waveform advances; low = waveform and prescaler freeze.
REQ-006 mode  input  2  0 SAW_UP, 1 SAW_DN, 2 TRIANGLE, 3 SQUARE.
REQ-007 lo  input  WIDTH  lower waveform bound, inclusive.
REQ-008 hi  input  WIDTH  upper waveform bound, inclusive.
REQ-009 step  input  WIDTH  increment/decrement applied per tick.
REQ-010 prescale  input  PRESCALE_W  a tick occurs every prescale+1 enabled cycles.
REQ-011 wave  output  WIDTH  current sample, registered.
REQ-012 pwm  output  1  PWM of wave, registered.
REQ-013 tick  output  1  one-cycle pulse in the cycle wave takes its new value.
REQ-014 wrap  output  1  one-cycle pulse coincident with tick at each period boundary.

Function
REQ-015 Prescaler: counter pcnt; when enable=1 and pcnt==prescale, pcnt SHALL go to 0 and the tick SHALL fire; otherwise pcnt SHALL increment. prescale=0 SHALL tick every enabled cycle.
REQ-016 prescale lowered below pcnt: the counter SHALL continue to wrap at 2^PRESCALE_W, with no early tick.
REQ-017 enable=0: pcnt, wave and direction SHALL hold; tick=0 and wrap=0.
REQ-018 All wave arithmetic SHALL be evaluated in WIDTH+1 bits. Results SHALL never wrap modulo 2^WIDTH.
REQ-019 Tick-time priority, highest first:
  (a) lo>=hi: wave<=lo, dir<=UP, no wrap.
  (b) wave<lo or wave>hi: wave<=lo, dir<=UP, no wrap.
  (c) the mode rule.
REQ-020 SAW_UP: if wave+step>hi then wave<=lo and wrap=1; else wave<=wave+step.
REQ-021 SAW_DN: if wave<lo+step then wave<=hi and wrap=1; else wave<=wave-step.
REQ-022 TRIANGLE, dir UP:
  - if wave+step>=hi: wave<=hi, dir<=DN;
  - else wave<=wave+step.
REQ-023 TRIANGLE, dir DN:
  - if wave<=lo+step: wave<=lo, dir<=UP, wrap=1;
  - else wave<=wave-step.
REQ-024 SQUARE: step is ignored.
  - wave==lo: wave<=hi.
  - wave!=lo: wave<=lo and wrap=1.
REQ-025 step=0 in SAW/TRIANGLE modes: wave SHALL hold, wrap SHALL stay 0, and tick SHALL still pulse.
REQ-026 A mode change SHALL take effect at the next tick, continuing from the current wave. A change away from TRIANGLE SHALL force dir<=UP.
REQ-027 lo, hi, step and mode SHALL be sampled only in tick cycles. No other latency applies.
REQ-028 PWM counter:
  - pwm_cnt (WIDTH bits) SHALL free-run, +1 every clock regardless of enable, wrapping at 2^WIDTH.
  - pwm SHALL be registered (pwm_cnt < wave), one cycle of latency.
REQ-029 PWM extremes: wave=0 SHALL give constant 0; wave=2^WIDTH-1 SHALL give high for 2^WIDTH-1 of every 2^WIDTH cycles.

Reset
REQ-030 rst=1 SHALL force wave=0, dir=UP, pcnt=0, pwm_cnt=0, pwm=0, tick=0, wrap=0 on the next edge, overriding enable.
REQ-031 rst asserted mid-period SHALL discard all progress. The first tick after release SHALL follow REQ-019, so wave goes to lo when lo>0.

Verification
REQ-032 WIDTH=8, SAW_UP, lo=10, hi=20, step=4, prescale=0:
  - wave SHALL go 0->10->14->18->10;
  - wrap SHALL be high only on the ->10 tick after 18.
REQ-033 TRIANGLE, lo=0, hi=255, step=100:
  - wave SHALL go 0,100,200,255,155,55,0,100;
  - wrap SHALL pulse on reaching 0;
  - wave SHALL never exceed 255.
REQ-034 prescale=3, enable toggled low for 5 cycles mid-count:
  - tick SHALL occur every 4 enabled cycles;
  - during the low window, pcnt and wave SHALL be unchanged.
REQ-035 SAW_DN, lo=0, hi=9, step=3, starting at 9:
  - wave SHALL go 9,6,3,0,9;
  - wrap SHALL pulse on the 0->9 tick.
REQ-036 Fault conditions:
  - lo=50, hi=40: wave SHALL hold 50 with wrap=0.
  - hi then set to 30 while wave=45 (lo=10): the next tick SHALL give wave=10.
REQ-037 PWM: over 256 cycles, pwm high count SHALL be 0 for wave=0, 64 for wave=64, and 255 for wave=255.

Source files
------------

// File: rtl/wave_gen_if.sv
// Control/sample bundle for wave_gen: configuration inputs in, waveform and PWM out.
interface wave_gen_if #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned PRESCALE_W = 16
) ();
  logic                  enable;
  logic [1:0]            mode;
  logic [WIDTH-1:0]      lo;
  logic [WIDTH-1:0]      hi;
  logic [WIDTH-1:0]      step;
  logic [PRESCALE_W-1:0] prescale;
  logic [WIDTH-1:0]      wave;
  logic                  pwm;
  logic                  tick;
  logic                  wrap;

  modport master (
    output enable, mode, lo, hi, step, prescale,
    input  wave, pwm, tick, wrap
  );

  modport slave (
    input  enable, mode, lo, hi, step, prescale,
    output wave, pwm, tick, wrap
  );
endinterface

// File: rtl/wave_gen.sv
// Prescaled saw/triangle/square waveform generator with a free-running PWM of the sample.
module wave_gen #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned PRESCALE_W = 16
) (
  input logic       clk,
  input logic       rst,
  wave_gen_if.slave bus
);

  typedef enum logic [1:0] {ModeSawUp, ModeSawDn, ModeTri, ModeSquare} mode_e;
  typedef enum logic {DirUp, DirDn} dir_e;

  logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
  logic [WIDTH-1:0]      wave_q, wave_d;
  logic [WIDTH-1:0]      pwm_cnt_q;
  dir_e                  dir_q, dir_d;
  logic                  tick_q, tick_d;
  logic                  wrap_q, wrap_d;
  logic                  pwm_q;
  logic                  fire;
  mode_e                 mode;

  // One spare bit so sums above hi and differences below lo never alias.
  logic [WIDTH:0] w_ext, lo_ext, hi_ext, step_ext, up_sum, dn_diff, lo_plus;

  assign w_ext    = {1'b0, wave_q};
  assign lo_ext   = {1'b0, bus.lo};
  assign hi_ext   = {1'b0, bus.hi};
  assign step_ext = {1'b0, bus.step};
  assign up_sum   = w_ext + step_ext;
  assign dn_diff  = w_ext - step_ext;
  assign lo_plus  = lo_ext + step_ext;
  assign mode     = mode_e'(bus.mode);
  assign fire     = bus.enable && (pcnt_q == bus.prescale);

  always_comb begin
    pcnt_d = pcnt_q;
    wave_d = wave_q;
    dir_d  = dir_q;
    tick_d = 1'b0;
    wrap_d = 1'b0;
    if (bus.enable) begin
      pcnt_d = fire ? '0 : pcnt_q + PRESCALE_W'(1);
    end
    if (fire) begin
      tick_d = 1'b1;
      if (lo_ext >= hi_ext || w_ext < lo_ext || w_ext > hi_ext) begin
        wave_d = bus.lo;
        dir_d  = DirUp;
      end else begin
        if (mode != ModeTri) dir_d = DirUp;
        // A zero step holds the sample without flagging a period boundary.
        if (step_ext == '0 && mode != ModeSquare) begin
          wave_d = wave_q;
        end else begin
          unique case (mode)
            ModeSawUp: begin
              if (up_sum > hi_ext) begin
                wave_d = bus.lo;
                wrap_d = 1'b1;
              end else begin
                wave_d = up_sum[WIDTH-1:0];
              end
            end
            ModeSawDn: begin
              if (w_ext < lo_plus) begin
                wave_d = bus.hi;
                wrap_d = 1'b1;
              end else begin
                wave_d = dn_diff[WIDTH-1:0];
              end
            end
            ModeTri: begin
              if (dir_q == DirUp) begin
                if (up_sum >= hi_ext) begin
                  wave_d = bus.hi;
                  dir_d  = DirDn;
                end else begin
                  wave_d = up_sum[WIDTH-1:0];
                end
              end else begin
                if (w_ext <= lo_plus) begin
                  wave_d = bus.lo;
                  dir_d  = DirUp;
                  wrap_d = 1'b1;
                end else begin
                  wave_d = dn_diff[WIDTH-1:0];
                end
              end
            end
            ModeSquare: begin
              if (wave_q == bus.lo) begin
                wave_d = bus.hi;
              end else begin
                wave_d = bus.lo;
                wrap_d = 1'b1;
              end
            end
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_q    <= '0;
      wave_q    <= '0;
      dir_q     <= DirUp;
      tick_q    <= 1'b0;
      wrap_q    <= 1'b0;
      pwm_cnt_q <= '0;
      pwm_q     <= 1'b0;
    end else begin
      pcnt_q    <= pcnt_d;
      wave_q    <= wave_d;
      dir_q     <= dir_d;
      tick_q    <= tick_d;
      wrap_q    <= wrap_d;
      pwm_cnt_q <= pwm_cnt_q + WIDTH'(1);
      pwm_q     <= (pwm_cnt_q < wave_q);
    end
  end

  assign bus.wave = wave_q;
  assign bus.tick = tick_q;
  assign bus.wrap = wrap_q;
  assign bus.pwm  = pwm_q;

endmodule
